// File: rtl/carbonz380_mode_stack.sv
// carbonz380_mode_stack: MODEUP/RETMD tier transitions with a return-PC mode stack.
// Owns the architectural tier register and the mode-stack pointer.
// Optional build macro: CARBON_MODESTACK_PARITY_EN adds an even-parity bit per
// stack entry; a RETMD that pops a corrupted entry traps with cause 0x14.
module carbonz380_mode_stack #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RESET_TIER = 0,
  parameter int unsigned MAX_TIER   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [7:0]  req_tier,
  input  logic [31:0] req_ret_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_ok,
  output logic [31:0] rsp_pc,
  output logic [31:0] rsp_cause,
  output logic [7:0]  tier_o,
  output logic [3:0]  sp_o
);

  localparam int unsigned TIER_W = 8;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned SP_W   = 4;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic        OP_MODEUP             = 1'b0;
  localparam logic [31:0] CAUSE_MODEUP_INVALID  = 32'h0000_0012;
  localparam logic [31:0] CAUSE_RETMD_UNDERFLOW = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic              ready_q, ready_d;
  logic              op_q, op_d;
  logic [TIER_W-1:0] treq_q, treq_d;
  logic [PC_W-1:0]   pc_req_q, pc_req_d;
  logic [TIER_W-1:0] tier_q, tier_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_ok_q, rsp_ok_d;
  logic [PC_W-1:0]   rsp_pc_q, rsp_pc_d;
  logic [31:0]       rsp_cause_q, rsp_cause_d;

  logic              push_en;
  logic              modeup_legal;
  logic              parity_err;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [TIER_W-1:0] rd_tier;
  logic [PC_W-1:0]   rd_pc;

  logic [TIER_W-1:0] tier_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];

  assign wr_idx  = IDX_W'(sp_q);
  assign rd_idx  = IDX_W'(sp_q - SP_W'(1));
  assign rd_tier = tier_mem[rd_idx];
  assign rd_pc   = pc_mem[rd_idx];

  // MODEUP must raise the tier, stay within the legal range and find a free slot
  assign modeup_legal = (treq_q > tier_q) && (treq_q <= TIER_W'(MAX_TIER)) &&
                        (sp_q < SP_W'(DEPTH));

  // Stack storage: written only on a legal MODEUP, contents need no reset
  always_ff @(posedge clk) begin
    if (push_en) begin
      tier_mem[wr_idx] <= tier_q;
      pc_mem[wr_idx]   <= pc_req_q;
    end
  end

`ifdef CARBON_MODESTACK_PARITY_EN
  localparam logic [31:0] CAUSE_PARITY = 32'h0000_0014;

  logic par_mem [DEPTH];

  // Even parity over {tier, pc} captured alongside each pushed entry
  always_ff @(posedge clk) begin
    if (push_en) begin
      par_mem[wr_idx] <= ^{tier_q, pc_req_q};
    end
  end

  assign parity_err = ^{rd_tier, rd_pc, par_mem[rd_idx]};
`else
  assign parity_err = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      op_q        <= 1'b0;
      treq_q      <= '0;
      pc_req_q    <= '0;
      tier_q      <= TIER_W'(RESET_TIER);
      sp_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_ok_q    <= 1'b0;
      rsp_pc_q    <= '0;
      rsp_cause_q <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      op_q        <= op_d;
      treq_q      <= treq_d;
      pc_req_q    <= pc_req_d;
      tier_q      <= tier_d;
      sp_q        <= sp_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ok_q    <= rsp_ok_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_cause_q <= rsp_cause_d;
    end
  end

  // Next state: accept in IDLE, evaluate in EXEC, hold response in RESP; flush wins
  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    op_d        = op_q;
    treq_d      = treq_q;
    pc_req_d    = pc_req_q;
    tier_d      = tier_q;
    sp_d        = sp_q;
    rsp_valid_d = rsp_valid_q;
    rsp_ok_d    = rsp_ok_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_cause_d = rsp_cause_q;
    push_en     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          op_d     = req_op;
          treq_d   = req_tier;
          pc_req_d = req_ret_pc;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_ok_d    = 1'b0;
        rsp_pc_d    = '0;
        rsp_cause_d = '0;
        if (op_q == OP_MODEUP) begin
          rsp_pc_d = pc_req_q;
          if (modeup_legal) begin
            push_en  = 1'b1;
            tier_d   = treq_q;
            sp_d     = sp_q + SP_W'(1);
            rsp_ok_d = 1'b1;
          end else begin
            rsp_cause_d = CAUSE_MODEUP_INVALID;
          end
        end else if (sp_q == '0) begin
          rsp_cause_d = CAUSE_RETMD_UNDERFLOW;
        end else if (parity_err) begin
`ifdef CARBON_MODESTACK_PARITY_EN
          rsp_cause_d = CAUSE_PARITY;
`endif
        end else begin
          tier_d   = rd_tier;
          sp_d     = sp_q - SP_W'(1);
          rsp_ok_d = 1'b1;
          rsp_pc_d = rd_pc;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);

    if (flush) begin
      state_d     = S_IDLE;
      ready_d     = 1'b1;
      tier_d      = TIER_W'(RESET_TIER);
      sp_d        = '0;
      rsp_valid_d = 1'b0;
      rsp_ok_d    = 1'b0;
      rsp_pc_d    = '0;
      rsp_cause_d = '0;
      push_en     = 1'b0;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_ok    = rsp_ok_q;
  assign rsp_pc    = rsp_pc_q;
  assign rsp_cause = rsp_cause_q;
  assign tier_o    = tier_q;
  assign sp_o      = sp_q;

endmodule

// File: tb/tb_carbonz380_mode_stack.sv
// Self-checking bench for carbonz380_mode_stack: queue-based stack model,
// per-cycle output compare, directed scenarios plus randomized traffic.
module tb_carbonz380_mode_stack;

  localparam int unsigned DEP   = 4;
  localparam int unsigned MAXT  = 6;
  localparam bit          MODEUP = 1'b0;
  localparam bit          RETMD  = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_op = 1'b0;
  logic [7:0]  req_tier = '0;
  logic [31:0] req_ret_pc = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_ok;
  logic [31:0] rsp_pc;
  logic [31:0] rsp_cause;
  logic [7:0]  tier_o;
  logic [3:0]  sp_o;

  carbonz380_mode_stack #(
    .DEPTH     (DEP),
    .RESET_TIER(0),
    .MAX_TIER  (MAXT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_tier  (req_tier),
    .req_ret_pc(req_ret_pc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_ok    (rsp_ok),
    .rsp_pc    (rsp_pc),
    .rsp_cause (rsp_cause),
    .tier_o    (tier_o),
    .sp_o      (sp_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Architectural model: current tier plus a LIFO of {tier, pc}
  logic [7:0]  m_tier = '0;
  logic [7:0]  q_tier[$];
  logic [31:0] q_pc[$];
  logic        p_ok;
  logic [31:0] p_pc;
  logic [31:0] p_cause;

  // Expected output values for the per-cycle compare
  bit          chk_en = 1'b0;
  logic        exp_ready = 1'b0;
  logic        exp_valid = 1'b0;
  logic        exp_ok = 1'b0;
  logic [31:0] exp_pc = '0;
  logic [31:0] exp_cause = '0;
  logic [7:0]  exp_tier = '0;
  logic [3:0]  exp_sp = '0;

  // DUT response snapshot for literal pins
  logic        r_ok;
  logic [31:0] r_pc;
  logic [31:0] r_cause;
  logic [7:0]  r_tier;
  logic [3:0]  r_sp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_op(input bit op, input logic [7:0] t, input logic [31:0] pc);
    p_ok = 1'b0; p_pc = '0; p_cause = '0;
    if (op == MODEUP) begin
      p_pc = pc;
      if (t > m_tier && t <= 8'(MAXT) && q_tier.size() < DEP) begin
        q_tier.push_back(m_tier);
        q_pc.push_back(pc);
        m_tier = t;
        p_ok = 1'b1;
      end else begin
        p_cause = 32'h12;
      end
    end else begin
      if (q_tier.size() != 0) begin
        m_tier = q_tier.pop_back();
        p_pc = q_pc.pop_back();
        p_ok = 1'b1;
      end else begin
        p_cause = 32'h13;
      end
    end
  endtask

  task automatic model_clear();
    q_tier.delete();
    q_pc.delete();
    m_tier = '0;
    exp_tier = '0;
    exp_sp = '0;
    exp_valid = 1'b0;
    exp_ready = 1'b1;
  endtask

  task automatic noise();
    req_valid  = 1'($urandom_range(0, 1));
    req_op     = 1'($urandom_range(0, 1));
    req_tier   = 8'($urandom);
    req_ret_pc = $urandom;
  endtask

  // One full transaction: called one step after an edge with the DUT in IDLE
  task automatic do_op(input bit op, input logic [7:0] t, input logic [31:0] pc, input int hold);
    req_valid = 1'b1; req_op = op; req_tier = t; req_ret_pc = pc;
    @(posedge clk); #1;
    exp_ready = 1'b0;
    noise();
    rsp_ready = 1'($urandom_range(0, 1));
    model_op(op, t, pc);
    @(posedge clk); #1;
    exp_valid = 1'b1; exp_ok = p_ok; exp_pc = p_pc; exp_cause = p_cause;
    exp_tier = m_tier; exp_sp = 4'(q_tier.size());
    r_ok = rsp_ok; r_pc = rsp_pc; r_cause = rsp_cause; r_tier = tier_o; r_sp = sp_o;
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      noise();
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    exp_valid = 1'b0;
    exp_ready = 1'b1;
  endtask

  // Flush while in IDLE (with a competing request), EXEC or RESP
  task automatic flush_op(input int phase);
    if (phase > 0) begin
      req_valid = 1'b1; req_op = 1'($urandom_range(0, 1));
      req_tier = 8'($urandom_range(0, 7)); req_ret_pc = $urandom;
      model_op(req_op, req_tier, req_ret_pc);
      @(posedge clk); #1;
      exp_ready = 1'b0;
      req_valid = 1'b0;
      if (phase == 2) begin
        @(posedge clk); #1;
        exp_valid = 1'b1; exp_ok = p_ok; exp_pc = p_pc; exp_cause = p_cause;
        exp_tier = m_tier; exp_sp = 4'(q_tier.size());
      end
    end else begin
      req_valid = 1'b1; req_op = MODEUP; req_tier = m_tier + 8'd1; req_ret_pc = $urandom;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    req_valid = 1'b0;
    model_clear();
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      chk("tier_o", 32'(tier_o), 32'(exp_tier));
      chk("sp_o", 32'(sp_o), 32'(exp_sp));
      if (exp_valid) begin
        chk("rsp_ok", 32'(rsp_ok), 32'(exp_ok));
        chk("rsp_cause", rsp_cause, exp_cause);
        if (exp_ok) chk("rsp_pc", rsp_pc, exp_pc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t;
    bit         op;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_tier", 32'(tier_o), 32'd0);
    chk("rst_sp", 32'(sp_o), 32'd0);
    chk("rst_rsp_pc", rsp_pc, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    model_clear();
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Basic MODEUP then RETMD
    do_op(MODEUP, 8'd1, 32'h0000_0100, 0);
    chk("mu1_ok", 32'(r_ok), 32'd1);
    chk("mu1_pc", r_pc, 32'h100);
    chk("mu1_tier", 32'(r_tier), 32'd1);
    chk("mu1_sp", 32'(r_sp), 32'd1);
    do_op(RETMD, 8'd0, 32'hDEAD_BEEF, 0);
    chk("rm1_pc", r_pc, 32'h100);
    chk("rm1_tier", 32'(r_tier), 32'd0);
    chk("rm1_sp", 32'(r_sp), 32'd0);

    // Each tier from P0 and back
    for (int n = 1; n <= 6; n++) begin
      do_op(MODEUP, 8'(n), 32'h1000 + 32'(n), 0);
      chk("step_up_tier", 32'(r_tier), 32'(n));
      chk("step_up_sp", 32'(r_sp), 32'd1);
      do_op(RETMD, 8'd0, 32'h0, 1);
      chk("step_dn_tier", 32'(r_tier), 32'd0);
      chk("step_dn_sp", 32'(r_sp), 32'd0);
    end
    do_op(MODEUP, 8'd7, 32'h700, 0);
    chk("mu7_ok", 32'(r_ok), 32'd0);
    chk("mu7_cause", r_cause, 32'h12);
    chk("mu7_tier", 32'(r_tier), 32'd0);

    // Fill to DEPTH, overflow, drain, underflow
    for (int n = 1; n <= 4; n++) do_op(MODEUP, 8'(n), 32'h2000 + 32'(n), 0);
    chk("full_sp", 32'(r_sp), 32'd4);
    do_op(MODEUP, 8'd5, 32'h2005, 0);
    chk("ovf_cause", r_cause, 32'h12);
    chk("ovf_sp", 32'(r_sp), 32'd4);
    for (int n = 3; n >= 0; n--) begin
      do_op(RETMD, 8'd0, 32'h0, 0);
      chk("drain_tier", 32'(r_tier), 32'(n));
      chk("drain_pc", r_pc, 32'h2000 + 32'(n + 1));
    end
    do_op(RETMD, 8'd0, 32'h0, 0);
    chk("udf_ok", 32'(r_ok), 32'd0);
    chk("udf_cause", r_cause, 32'h13);

    // Response back-pressure, then flush in EXEC
    do_op(MODEUP, 8'd2, 32'h3000, 5);
    flush_op(1);
    chk("flush_tier", 32'(tier_o), 32'd0);
    chk("flush_sp", 32'(sp_o), 32'd0);
    chk("flush_valid", 32'(rsp_valid), 32'd0);
    do_op(MODEUP, 8'd3, 32'h3100, 0);
    flush_op(2);
    do_op(MODEUP, 8'd1, 32'h3200, 0);
    flush_op(0);

    // Asynchronous reset in the middle of an op
    do_op(MODEUP, 8'd3, 32'h4000, 0);
    req_valid = 1'b1; req_op = MODEUP; req_tier = 8'd5; req_ret_pc = 32'h4100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_tier", 32'(tier_o), 32'd0);
    chk("arst_sp", 32'(sp_o), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    chk("arst_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    model_clear();
    chk_en = 1'b1;

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 29) == 0) begin
        flush_op(int'($urandom_range(0, 2)));
      end else begin
        op = ($urandom_range(0, 99) < 55) ? MODEUP : RETMD;
        case ($urandom_range(0, 9))
          0:       t = 8'hFF;
          1:       t = 8'h80;
          2, 3, 4: t = 8'($urandom_range(0, 8));
          default: t = m_tier + 8'($urandom_range(1, 2));
        endcase
        do_op(op, t, $urandom, int'($urandom_range(0, 3)));
      end
    end

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
